uart_rx_ext: RTL and testbench

Parametrised UART receiver for the FPGA serial path, replacing the fixed 8N1 receiver. Data width, parity mode and stop-bit count are set by parameters. It adds an input synchroniser, a 3-sample majority vote and false-start rejection. Received words are delivered through a valid/ready handshake with parity, framing and overrun flags, so the consumer FSM can apply back-pressure.

---
 rtl/uart_rx_ext.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with a 2-FF synchroniser,
// a 3-sample majority vote, false-start rejection and a valid/ready output.
// Ports: clk, reset (sync, active-high), rxd (async serial in), enable,
//   data_out/data_valid/data_ready (word handshake), parity_err,
//   frame_err, overrun (frames dropped since last accept), busy (not idle).
module uart_rx_ext #(
    parameter int DATA_BITS = 8,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CPB = CLOCK_HZ / BAUD_RATE;
    localparam int H   = CPB / 2;
    localparam int CW  = $clog2(CPB);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_S2   = CW'(H + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dv_q, dv_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;

    logic rxs;
    logic maj;
    logic par_exp;
    logic at_s2;
    logic wrap;
    logic done;
    logic fe_final;

    assign rxs     = sync_q[1];
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    assign par_exp = (PARITY == 1) ? ~^shift_q : ^shift_q;
    assign at_s2   = (cnt_q == CNT_S2);
    assign wrap    = (cnt_q == CNT_LAST);

    always_comb begin
        sync_d   = {sync_q[0], rxd};
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        samp_d   = samp_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        dout_d   = dout_q;
        dv_d     = dv_q;
        pe_d     = pe_q;
        fe_d     = fe_q;
        ovr_d    = ovr_q;
        done     = 1'b0;
        fe_final = ferr_q;

        if (state_q != S_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) samp_d[0] = rxs;
            if (cnt_q == CNT_S1) samp_d[1] = rxs;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (enable && !rxs) state_d = S_START;
            end
            S_START: begin
                // A start bit that votes high is a line glitch.
                if (at_s2 && maj)  state_d = S_IDLE;
                else if (wrap)     state_d = S_DATA;
            end
            S_DATA: begin
                if (at_s2) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_s2) perr_d = (maj != par_exp);
                if (wrap)  state_d = S_STOP;
            end
            S_STOP: begin
                if (at_s2) begin
                    if (!maj) ferr_d = 1'b1;
                    fe_final = ferr_q | ~maj;
                    // Finish mid-bit so an immediately following start is seen.
                    if (bit_q == STOP_LAST) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                if (wrap) bit_d = bit_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done    = 1'b0;
        end

        if (dv_q && data_ready) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end
        if (done) begin
            if (!dv_q || data_ready) begin
                dout_d = shift_q;
                pe_d   = perr_q;
                fe_d   = fe_final;
                dv_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            samp_q  <= 2'b11;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: self-checking bench for uart_rx_ext.
// Three instances: 8N1 (0), 8E1 (1), 8N2 (2); CLKS_PER_BIT = 16.
module tb_uart_rx_ext;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       data_ready = 1'b1;
    logic [2:0] rxd = 3'b111;

    logic [7:0] dout [3];
    logic       dv [3];
    logic       pe [3];
    logic       fe [3];
    logic       ov [3];
    logic       bz [3];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [12:0] acc_q [$];
    int          dv_cnt [3] = '{0, 0, 0};
    int          busy_cnt [3] = '{0, 0, 0};
    int unsigned rise_cyc [3] = '{0, 0, 0};
    logic        dv_prev [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ext #(.DATA_BITS(8), .CLOCK_HZ(153_600), .BAUD_RATE(9600),
                  .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .rxd(rxd[0]), .enable(enable),
        .data_out(dout[0]), .data_valid(dv[0]), .data_ready(data_ready),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));

    uart_rx_ext #(.DATA_BITS(8), .CLOCK_HZ(153_600), .BAUD_RATE(9600),
                  .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .rxd(rxd[1]), .enable(enable),
        .data_out(dout[1]), .data_valid(dv[1]), .data_ready(data_ready),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));

    uart_rx_ext #(.DATA_BITS(8), .CLOCK_HZ(153_600), .BAUD_RATE(9600),
                  .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .rxd(rxd[2]), .enable(enable),
        .data_out(dout[2]), .data_valid(dv[2]), .data_ready(data_ready),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));

    // Records every accepted word as {inst, overrun, frame_err, parity_err, data}.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dv[i]) begin
                dv_cnt[i]++;
                if (!dv_prev[i]) rise_cyc[i] = cyc;
                if (data_ready)
                    acc_q.push_back({2'(i), ov[i], fe[i], pe[i], dout[i]});
            end
            if (bz[i]) busy_cnt[i]++;
            dv_prev[i] = dv[i];
        end
    end

    function automatic int pmode(input int inst);
        return (inst == 1) ? 2 : 0;
    endfunction

    function automatic int nstop(input int inst);
        return (inst == 2) ? 2 : 1;
    endfunction

    // Expected accepted word from the frame contents.
    function automatic logic [12:0] model(input int inst, input logic [7:0] d,
                                          input logic pbit, input logic [1:0] stops,
                                          input logic ovr);
        int   ones;
        logic pe_m;
        logic fe_m;
        ones = $countones(d) + int'(pbit);
        pe_m = 1'b0;
        if (pmode(inst) == 2) pe_m = (ones % 2) != 0;
        if (pmode(inst) == 1) pe_m = (ones % 2) == 0;
        fe_m = !stops[0] || (nstop(inst) == 2 && !stops[1]);
        return {2'(inst), ovr, fe_m, pe_m, d};
    endfunction

    // Called at a negedge; each line bit is held for 16 clocks.
    task automatic send(input int inst, input logic [7:0] d, input logic pbit,
                        input logic [1:0] stops, input int gap);
        logic [15:0] bits;
        int          n;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (pmode(inst) != 0) begin
            bits[n] = pbit;
            n++;
        end
        for (int s = 0; s < nstop(inst); s++) begin
            bits[n] = stops[s];
            n++;
        end
        for (int i = 0; i < n; i++) begin
            rxd[inst] = bits[i];
            repeat (16) @(negedge clk);
        end
        rxd[inst] = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dv[i], ov[i], fe[i], pe[i], bz[i], dout[i]} !== 13'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %b required 0", i,
                         {dv[i], ov[i], fe[i], pe[i], bz[i], dout[i]});
            end
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1_a5;
        int          d0;
        int unsigned c0;
        logic [12:0] got;
        logic [12:0] exp;
        acc_q.delete();
        d0 = dv_cnt[0];
        c0 = cyc;
        send(0, 8'hA5, 1'b0, 2'b11, 48);
        checks++;
        if (acc_q.size() != 1) begin
            errors++;
            $display("FAIL a5_count: got %0d words required 1", acc_q.size());
        end else begin
            got = acc_q.pop_front();
            exp = model(0, 8'hA5, 1'b0, 2'b11, 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL a5_word: got %h required %h", got, exp);
            end
        end
        checks++;
        if (rise_cyc[0] - c0 != 157) begin
            errors++;
            $display("FAIL a5_latency: got %0d required 157", rise_cyc[0] - c0);
        end
        checks++;
        if (dv_cnt[0] - d0 != 1) begin
            errors++;
            $display("FAIL a5_valid_width: got %0d required 1", dv_cnt[0] - d0);
        end
    endtask

    task automatic test_random(input int inst, input int nframes);
        logic [7:0]  d;
        logic        pbit;
        logic [1:0]  stops;
        logic [12:0] got;
        logic [12:0] exp;
        for (int k = 0; k < nframes; k++) begin
            acc_q.delete();
            d     = 8'($urandom);
            pbit  = 1'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send(inst, d, pbit, stops, 32);
            checks++;
            if (acc_q.size() != 1) begin
                errors++;
                $display("FAIL rand_count inst%0d: got %0d required 1",
                         inst, acc_q.size());
            end else begin
                got = acc_q.pop_front();
                exp = model(inst, d, pbit, stops, 1'b0);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rand_word inst%0d: got %h required %h",
                             inst, got, exp);
                end
            end
        end
    endtask

    task automatic test_parity;
        logic [12:0] got;
        logic [12:0] exp;
        for (int k = 0; k < 2; k++) begin
            acc_q.delete();
            send(1, 8'h03, (k == 0), 2'b11, 32);
            exp = model(1, 8'h03, (k == 0), 2'b11, 1'b0);
            checks++;
            if (acc_q.size() != 1) begin
                errors++;
                $display("FAIL parity_count: got %0d required 1", acc_q.size());
            end else begin
                got = acc_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL parity_word: got %h required %h", got, exp);
                end
            end
            checks++;
            if ({pe[1], dout[1]} !== {exp[8], exp[7:0]}) begin
                errors++;
                $display("FAIL parity_hold: got %h required %h",
                         {pe[1], dout[1]}, {exp[8], exp[7:0]});
            end
        end
    endtask

    task automatic test_stop2;
        logic [12:0] got;
        logic [12:0] exp;
        acc_q.delete();
        send(2, 8'hC3, 1'b0, 2'b01, 48);
        send(2, 8'h5A, 1'b0, 2'b11, 32);
        checks++;
        if (acc_q.size() != 2) begin
            errors++;
            $display("FAIL stop2_count: got %0d required 2", acc_q.size());
        end else begin
            got = acc_q.pop_front();
            exp = model(2, 8'hC3, 1'b0, 2'b01, 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stop2_ferr: got %h required %h", got, exp);
            end
            got = acc_q.pop_front();
            exp = model(2, 8'h5A, 1'b0, 2'b11, 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stop2_clean: got %h required %h", got, exp);
            end
        end
    endtask

    task automatic test_glitch;
        int b0;
        int d0;
        b0 = busy_cnt[0];
        d0 = dv_cnt[0];
        rxd[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (busy_cnt[0] - b0 != 10) begin
            errors++;
            $display("FAIL glitch_busy: got %0d cycles required 10",
                     busy_cnt[0] - b0);
        end
        checks++;
        if (dv_cnt[0] - d0 != 0 || bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got valid %0d busy %b required 0 0",
                     dv_cnt[0] - d0, bz[0]);
        end
    endtask

    task automatic test_overrun;
        logic [12:0] got;
        logic [12:0] exp;
        @(posedge clk);
        #1 data_ready = 1'b0;
        @(negedge clk);
        acc_q.delete();
        send(0, 8'h11, 1'b0, 2'b11, 32);
        send(0, 8'h22, 1'b0, 2'b11, 32);
        exp = model(0, 8'h11, 1'b0, 2'b11, 1'b1);
        checks++;
        if ({dv[0], ov[0], fe[0], pe[0], dout[0]} !== {1'b1, exp[10:0]}) begin
            errors++;
            $display("FAIL overrun_held: got %h required %h",
                     {dv[0], ov[0], fe[0], pe[0], dout[0]}, {1'b1, exp[10:0]});
        end
        repeat (20) @(negedge clk);
        checks++;
        if (dv[0] !== 1'b1 || acc_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_sticky: got valid %b words %0d required 1 0",
                     dv[0], acc_q.size());
        end
        @(posedge clk);
        #1 data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({dv[0], ov[0], dout[0]} !== {2'b00, 8'h11}) begin
            errors++;
            $display("FAIL overrun_accept: got %h required %h",
                     {dv[0], ov[0], dout[0]}, {2'b00, 8'h11});
        end
        checks++;
        if (acc_q.size() != 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d required 1", acc_q.size());
        end else begin
            got = acc_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL overrun_word: got %h required %h", got, exp);
            end
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [12:0] got;
        logic [12:0] exp;
        rxd[0] = 1'b0;
        repeat (16 + 16 * 3 + 5) @(negedge clk);
        checks++;
        if (bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b required 1", bz[0]);
        end
        reset  = 1'b1;
        rxd[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dv[i], ov[i], fe[i], pe[i], bz[i], dout[i]} !== 13'b0) begin
                errors++;
                $display("FAIL mid_reset inst%0d: got %b required 0", i,
                         {dv[i], ov[i], fe[i], pe[i], bz[i], dout[i]});
            end
        end
        repeat (32) @(negedge clk);
        acc_q.delete();
        send(0, 8'h7E, 1'b0, 2'b11, 32);
        checks++;
        if (acc_q.size() != 1) begin
            errors++;
            $display("FAIL mid_count: got %0d required 1", acc_q.size());
        end else begin
            got = acc_q.pop_front();
            exp = model(0, 8'h7E, 1'b0, 2'b11, 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_word: got %h required %h", got, exp);
            end
        end
    endtask

    task automatic test_enable_drop;
        logic [7:0]  d;
        logic [12:0] got;
        logic [12:0] exp;
        acc_q.delete();
        rxd[0] = 1'b0;
        repeat (16 + 16 * 4 + 3) @(negedge clk);
        enable = 1'b0;
        rxd[0] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({bz[0], dv[0], dout[0]} !== {2'b00, 8'h7E} || acc_q.size() != 0) begin
            errors++;
            $display("FAIL enable_abort: got %h words %0d required %h 0",
                     {bz[0], dv[0], dout[0]}, acc_q.size(), {2'b00, 8'h7E});
        end
        enable = 1'b1;
        repeat (32) @(negedge clk);
        d = 8'($urandom);
        send(0, d, 1'b0, 2'b11, 32);
        checks++;
        if (acc_q.size() != 1) begin
            errors++;
            $display("FAIL enable_count: got %0d required 1", acc_q.size());
        end else begin
            got = acc_q.pop_front();
            exp = model(0, d, 1'b0, 2'b11, 1'b0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL enable_word: got %h required %h", got, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  d [3];
        logic [12:0] got;
        logic [12:0] exp;
        acc_q.delete();
        for (int k = 0; k < 3; k++) begin
            d[k] = 8'($urandom);
            send(0, d[k], 1'b0, 2'b11, (k == 2) ? 32 : 0);
        end
        checks++;
        if (acc_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 3", acc_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                got = acc_q.pop_front();
                exp = model(0, d[k], 1'b0, 2'b11, 1'b0);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h required %h", k, got, exp);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_8n1_a5;
        test_random(0, 6);
        test_parity;
        test_random(1, 6);
        test_stop2;
        test_random(2, 6);
        test_glitch;
        test_overrun;
        test_reset_mid;
        test_enable_drop;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
